// File: rtl/bus_cycle_decoder.sv
// 68000 bus cycle decoder: region decode, byte-lane selects, registered DTACK/BERR
// with per-region wait states, bus-error timeout and the reset-time ROM boot overlay.
module bus_cycle_decoder #(
    parameter int unsigned RAM_HI      = 3,
    parameter int unsigned ROM_LO      = 56,
    parameter int unsigned ROM_HI      = 59,
    parameter int unsigned IO_LO       = 60,
    parameter int unsigned IO_HI       = 61,
    parameter int unsigned RAM_WS      = 0,
    parameter int unsigned ROM_WS      = 2,
    parameter int unsigned IO_WS       = 3,
    parameter int unsigned TIMEOUT     = 64,
    parameter int unsigned BOOT_CYCLES = 4,
    parameter int unsigned CW          = 8
) (
    input  logic       i_CLK,
    input  logic       i_RST_n,
    input  logic [5:0] i_A,
    input  logic       i_AS_n,
    input  logic       i_UDS_n,
    input  logic       i_LDS_n,
    input  logic       i_RW,
    input  logic       i_CPUSP_n,
    input  logic       i_EXPDTACK_n,
    output logic       o_DTACK_n,
    output logic       o_BERR_n,
    output logic       o_WR,
    output logic       o_EVENRAM_n,
    output logic       o_ODDRAM_n,
    output logic       o_EVENROM_n,
    output logic       o_ODDROM_n,
    output logic       o_IOSEL_n,
    output logic       o_EXPSEL_n,
    output logic       o_BOOT
);

    localparam int unsigned BW = $clog2(BOOT_CYCLES + 1);

    localparam logic [5:0] RAM_HI_B = 6'(RAM_HI);
    localparam logic [5:0] ROM_LO_B = 6'(ROM_LO);
    localparam logic [5:0] ROM_HI_B = 6'(ROM_HI);
    localparam logic [5:0] IO_LO_B  = 6'(IO_LO);
    localparam logic [5:0] IO_HI_B  = 6'(IO_HI);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_BERR
    } state_t;

    typedef enum logic [2:0] {
        R_NONE,
        R_RAM,
        R_ROM,
        R_IO,
        R_EXP,
        R_BADWR
    } region_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic [CW-1:0] to_cnt_q, to_cnt_d;
    logic [BW-1:0] boot_cnt_q, boot_cnt_d;
    logic          boot_q, boot_d;
    logic          dtack_n_q;
    logic          berr_n_q;

    logic          in_ram_c;
    logic          in_rom_c;
    logic          in_io_c;
    region_t       region_c;
    logic [CW-1:0] ws_c;

    assign in_ram_c = (i_A <= RAM_HI_B);
    assign in_rom_c = (i_A >= ROM_LO_B) && (i_A <= ROM_HI_B);
    assign in_io_c  = (i_A >= IO_LO_B) && (i_A <= IO_HI_B);

    // Region decode; boot overlay redirects low-block reads to ROM
    always_comb begin
        region_c = R_NONE;
        if (!i_AS_n && i_CPUSP_n) begin
            if (in_rom_c || (boot_q && in_ram_c && i_RW)) begin
                region_c = i_RW ? R_ROM : R_BADWR;
            end else if (in_ram_c) begin
                region_c = R_RAM;
            end else if (in_io_c) begin
                region_c = R_IO;
            end else begin
                region_c = R_EXP;
            end
        end
    end

    always_comb begin
        ws_c = '0;
        case (region_c)
            R_RAM:   ws_c = CW'(RAM_WS);
            R_ROM:   ws_c = CW'(ROM_WS);
            R_IO:    ws_c = CW'(IO_WS);
            default: ws_c = '0;
        endcase
    end

    // Selects are combinational and held inactive during reset
    assign o_EVENRAM_n = ~(i_RST_n & (region_c == R_RAM) & ~i_UDS_n);
    assign o_ODDRAM_n  = ~(i_RST_n & (region_c == R_RAM) & ~i_LDS_n);
    assign o_EVENROM_n = ~(i_RST_n & (region_c == R_ROM) & ~i_UDS_n);
    assign o_ODDROM_n  = ~(i_RST_n & (region_c == R_ROM) & ~i_LDS_n);
    assign o_IOSEL_n   = ~(i_RST_n & (region_c == R_IO));
    assign o_EXPSEL_n  = ~(i_RST_n & (region_c == R_EXP));
    assign o_WR        = ~i_RW;

    assign o_DTACK_n = dtack_n_q;
    assign o_BERR_n  = berr_n_q;
    assign o_BOOT    = boot_q;

    always_comb begin
        logic ack_c;
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        to_cnt_d   = to_cnt_q;
        boot_cnt_d = boot_cnt_q;
        boot_d     = boot_q;
        ack_c      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!i_AS_n) begin
                    to_cnt_d = '0;
                    case (region_c)
                        R_BADWR: state_d = S_BERR;
                        R_RAM, R_ROM, R_IO: begin
                            if (ws_c == '0) begin
                                state_d = S_ACK;
                            end else begin
                                state_d    = S_WAIT;
                                wait_cnt_d = ws_c;
                            end
                        end
                        default: begin
                            state_d    = S_WAIT;
                            wait_cnt_d = '0;
                        end
                    endcase
                end
            end

            S_WAIT: begin
                if (i_AS_n) begin
                    state_d    = S_IDLE;
                    wait_cnt_d = '0;
                    to_cnt_d   = '0;
                end else begin
                    case (region_c)
                        R_RAM, R_ROM, R_IO: begin
                            if (wait_cnt_q <= CW'(1)) begin
                                ack_c = 1'b1;
                            end else begin
                                wait_cnt_d = wait_cnt_q - CW'(1);
                            end
                        end
                        R_EXP:   ack_c = ~i_EXPDTACK_n;
                        default: ack_c = 1'b0;
                    endcase
                    // Acknowledge takes priority over a coincident timeout
                    if (ack_c) begin
                        state_d    = S_ACK;
                        wait_cnt_d = '0;
                        to_cnt_d   = '0;
                    end else if (to_cnt_q == CW'(TIMEOUT - 1)) begin
                        state_d    = S_BERR;
                        wait_cnt_d = '0;
                        to_cnt_d   = '0;
                    end else begin
                        to_cnt_d = to_cnt_q + CW'(1);
                    end
                end
            end

            S_ACK: begin
                if (i_AS_n) begin
                    state_d = S_IDLE;
                    if (boot_q) begin
                        boot_cnt_d = boot_cnt_q + BW'(1);
                        if (boot_cnt_q == BW'(BOOT_CYCLES - 1)) begin
                            boot_d = 1'b0;
                        end
                    end
                end
            end

            S_BERR: begin
                if (i_AS_n) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // A genuine ROM-block access ends the overlay as soon as it is acknowledged
        if ((state_q != S_ACK) && (state_d == S_ACK) && (region_c == R_ROM) && in_rom_c) begin
            boot_d = 1'b0;
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            to_cnt_q   <= '0;
            boot_cnt_q <= '0;
            boot_q     <= 1'b1;
            dtack_n_q  <= 1'b1;
            berr_n_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            to_cnt_q   <= to_cnt_d;
            boot_cnt_q <= boot_cnt_d;
            boot_q     <= boot_d;
            dtack_n_q  <= (state_d != S_ACK);
            berr_n_q   <= (state_d != S_BERR);
        end
    end

endmodule

// File: tb/tb_bus_cycle_decoder.sv
// Testbench for bus_cycle_decoder: directed and random bus cycles checked against
// a region/latency model derived from the address map and timing rules.
module tb_bus_cycle_decoder;

    localparam int RG_NONE  = 0;
    localparam int RG_RAM   = 1;
    localparam int RG_ROM   = 2;
    localparam int RG_IO    = 3;
    localparam int RG_EXP   = 4;
    localparam int RG_BADWR = 5;
    localparam int TMO      = 64;

    logic       i_CLK = 1'b0;
    logic       i_RST_n;
    logic [5:0] i_A;
    logic       i_AS_n, i_UDS_n, i_LDS_n, i_RW, i_CPUSP_n, i_EXPDTACK_n;
    logic       o_DTACK_n, o_BERR_n, o_WR;
    logic       o_EVENRAM_n, o_ODDRAM_n, o_EVENROM_n, o_ODDROM_n, o_IOSEL_n, o_EXPSEL_n;
    logic       o_BOOT;

    int total = 0;
    int bad   = 0;
    bit model_boot;
    int model_cnt;

    bus_cycle_decoder dut (
        .i_CLK        (i_CLK),
        .i_RST_n      (i_RST_n),
        .i_A          (i_A),
        .i_AS_n       (i_AS_n),
        .i_UDS_n      (i_UDS_n),
        .i_LDS_n      (i_LDS_n),
        .i_RW         (i_RW),
        .i_CPUSP_n    (i_CPUSP_n),
        .i_EXPDTACK_n (i_EXPDTACK_n),
        .o_DTACK_n    (o_DTACK_n),
        .o_BERR_n     (o_BERR_n),
        .o_WR         (o_WR),
        .o_EVENRAM_n  (o_EVENRAM_n),
        .o_ODDRAM_n   (o_ODDRAM_n),
        .o_EVENROM_n  (o_EVENROM_n),
        .o_ODDROM_n   (o_ODDROM_n),
        .o_IOSEL_n    (o_IOSEL_n),
        .o_EXPSEL_n   (o_EXPSEL_n),
        .o_BOOT       (o_BOOT)
    );

    always #5 i_CLK = ~i_CLK;

    function automatic logic [5:0] sel_vec();
        return {o_EVENRAM_n, o_ODDRAM_n, o_EVENROM_n, o_ODDROM_n, o_IOSEL_n, o_EXPSEL_n};
    endfunction

    function automatic int exp_region(int blk, bit rw, bit boot, bit cpusp);
        if (!cpusp) return RG_NONE;
        if ((blk >= 56 && blk <= 59) || (boot && blk <= 3 && rw)) return rw ? RG_ROM : RG_BADWR;
        if (blk <= 3) return RG_RAM;
        if (blk >= 60 && blk <= 61) return RG_IO;
        return RG_EXP;
    endfunction

    function automatic logic [5:0] exp_sel(int rg, bit uds, bit lds);
        bit ram, rom;
        ram = (rg == RG_RAM);
        rom = (rg == RG_ROM);
        return {!(ram && !uds), !(ram && !lds), !(rom && !uds), !(rom && !lds),
                !(rg == RG_IO), !(rg == RG_EXP)};
    endfunction

    // Edges counted from the first edge that samples AS low (that edge = 1)
    function automatic int exp_lat(int rg, int expdly);
        case (rg)
            RG_RAM:   return 1;
            RG_ROM:   return 3;
            RG_IO:    return 4;
            RG_BADWR: return 1;
            RG_EXP:   return (expdly >= 0 && expdly <= TMO - 1) ? expdly + 2 : TMO + 1;
            default:  return TMO + 1;
        endcase
    endfunction

    function automatic bit exp_ack(int rg, int expdly);
        if (rg == RG_RAM || rg == RG_ROM || rg == RG_IO) return 1'b1;
        if (rg == RG_EXP) return (expdly >= 0 && expdly <= TMO - 1);
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_CLK);
        #1;
    endtask

    task automatic idle_inputs();
        i_A = 6'd0; i_AS_n = 1'b1; i_UDS_n = 1'b1; i_LDS_n = 1'b1;
        i_RW = 1'b1; i_CPUSP_n = 1'b1; i_EXPDTACK_n = 1'b1;
    endtask

    task automatic do_reset();
        i_RST_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        i_RST_n = 1'b1;
        model_boot = 1'b1;
        model_cnt  = 0;
        tick();
    endtask

    // One full bus cycle; expdly<0 means expansion never acknowledges
    task automatic run_cycle(input string tag, input int blk, input bit rw, input bit uds,
                             input bit lds, input bit cpusp, input int expdly);
        int   rg, lat_e, got;
        bit   ack_e, realrom;
        rg      = exp_region(blk, rw, model_boot, cpusp);
        lat_e   = exp_lat(rg, expdly);
        ack_e   = exp_ack(rg, expdly);
        realrom = (rg == RG_ROM) && blk >= 56 && blk <= 59;
        i_A = 6'(blk); i_RW = rw; i_UDS_n = uds; i_LDS_n = lds; i_CPUSP_n = cpusp;
        i_EXPDTACK_n = 1'b1; i_AS_n = 1'b0;
        #1;
        chk($sformatf("%s.sel", tag), 32'(sel_vec()), 32'(exp_sel(rg, uds, lds)));
        chk($sformatf("%s.wr", tag), 32'(o_WR), 32'(!rw));
        got = 0;
        for (int e = 1; e <= TMO + 16 && got == 0; e++) begin
            tick();
            if (!o_DTACK_n || !o_BERR_n) got = e;
            if (expdly >= 0 && e == expdly + 1) i_EXPDTACK_n = 1'b0;
        end
        chk($sformatf("%s.lat", tag), 32'(got), 32'(lat_e));
        chk($sformatf("%s.kind", tag), 32'({o_DTACK_n, o_BERR_n}), ack_e ? 32'h1 : 32'h2);
        chk($sformatf("%s.boot_ack", tag), 32'(o_BOOT), 32'(model_boot && !(ack_e && realrom)));
        i_AS_n = 1'b1; i_UDS_n = 1'b1; i_LDS_n = 1'b1; i_EXPDTACK_n = 1'b1;
        tick();
        if (ack_e && realrom) begin
            model_boot = 1'b0;
        end else if (ack_e && model_boot) begin
            model_cnt++;
            if (model_cnt == 4) model_boot = 1'b0;
        end
        chk($sformatf("%s.release", tag), 32'({o_DTACK_n, o_BERR_n}), 32'h3);
        chk($sformatf("%s.boot", tag), 32'(o_BOOT), 32'(model_boot));
        chk($sformatf("%s.idlesel", tag), 32'(sel_vec()), 32'h3F);
    endtask

    initial begin
        int cls, blk, dly;
        i_RST_n = 1'b1;
        idle_inputs();
        #1 i_RST_n = 1'b0;
        i_AS_n = 1'b0; i_UDS_n = 1'b0; i_LDS_n = 1'b0;
        #1;
        chk("rst.sel", 32'(sel_vec()), 32'h3F);
        chk("rst.dtack", 32'(o_DTACK_n), 32'h1);
        chk("rst.berr", 32'(o_BERR_n), 32'h1);
        chk("rst.boot", 32'(o_BOOT), 32'h1);
        do_reset();

        // Boot overlay: four ROM-mirrored reads at block 0, then RAM
        for (int i = 0; i < 4; i++) run_cycle($sformatf("boot%0d", i), 0, 1, 0, 0, 1, -1);
        chk("boot.cleared", 32'(o_BOOT), 32'h0);
        run_cycle("ram_rd", 0, 1, 0, 0, 1, -1);
        run_cycle("ram_wr_odd", 1, 0, 1, 0, 1, -1);
        run_cycle("io_rd", 60, 1, 0, 0, 1, -1);
        run_cycle("exp_rd", 62, 1, 0, 0, 1, 3);
        run_cycle("rom_badwr", 56, 0, 0, 0, 1, -1);
        run_cycle("exp_tmo", 62, 1, 0, 0, 1, -1);
        run_cycle("cpusp_tmo", 60, 1, 0, 0, 0, -1);
        run_cycle("exp_ack_at_tmo", 63, 1, 0, 0, 1, 63);
        run_cycle("exp_ack_62", 62, 1, 0, 1, 1, 62);
        run_cycle("rom_rd", 59, 1, 1, 0, 1, -1);

        // Aborted IO cycle: AS released during wait states
        i_A = 6'd60; i_RW = 1'b1; i_UDS_n = 1'b0; i_LDS_n = 1'b0; i_AS_n = 1'b0;
        tick();
        tick();
        i_AS_n = 1'b1; i_UDS_n = 1'b1; i_LDS_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("abort%0d", i), 32'({o_DTACK_n, o_BERR_n}), 32'h3);
        end
        run_cycle("post_abort", 61, 1, 0, 0, 1, -1);

        // Reset asserted mid IO wait
        i_A = 6'd60; i_RW = 1'b1; i_UDS_n = 1'b0; i_LDS_n = 1'b0; i_AS_n = 1'b0;
        tick();
        tick();
        i_RST_n = 1'b0;
        #1;
        chk("rst_wait.strobes", 32'({o_DTACK_n, o_BERR_n}), 32'h3);
        chk("rst_wait.boot", 32'(o_BOOT), 32'h1);
        chk("rst_wait.sel", 32'(sel_vec()), 32'h3F);
        do_reset();

        // Reset asserted while DTACK is low
        i_A = 6'd2; i_RW = 1'b0; i_UDS_n = 1'b0; i_LDS_n = 1'b0; i_AS_n = 1'b0;
        tick();
        chk("ack_pre_rst", 32'(o_DTACK_n), 32'h0);
        i_RST_n = 1'b0;
        #1;
        chk("rst_ack.dtack", 32'(o_DTACK_n), 32'h1);
        do_reset();

        // Genuine ROM access ends the overlay early
        run_cycle("ovl0", 0, 1, 0, 0, 1, -1);
        run_cycle("ovl_rom", 57, 1, 0, 0, 1, -1);
        run_cycle("ovl_after", 0, 1, 0, 0, 1, -1);

        do_reset();
        for (int n = 0; n < 40; n++) begin
            cls = $urandom_range(0, 5);
            case (cls)
                0:       blk = $urandom_range(0, 3);
                1:       blk = $urandom_range(56, 59);
                2:       blk = $urandom_range(60, 61);
                3:       blk = $urandom_range(4, 55);
                4:       blk = $urandom_range(62, 63);
                default: blk = $urandom_range(0, 63);
            endcase
            dly = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 6);
            run_cycle($sformatf("rnd%0d", n), blk, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 9) != 0), dly);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
